// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external combinational ALU among NREQ requesters
// Optional macro ALU_ARB_LOCK_EN adds req_lock so one requester can hold the ALU across several ops.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_srca,
  input  logic [NREQ*W-1:0] req_srcb,
  input  logic [NREQ*5-1:0] req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [NREQ*W-1:0] rsp_res,
  output logic [NREQ-1:0]   rsp_flag,
  output logic [NREQ-1:0]   rsp_err,
  output logic [W-1:0]      alu_srca,
  output logic [W-1:0]      alu_srcb,
  output logic [4:0]        alu_op,
  input  logic [W-1:0]      alu_res,
  input  logic              alu_flag
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     rr_last_q, rr_last_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NREQ*W-1:0] rsp_res_q, rsp_res_d;
  logic [NREQ-1:0]   rsp_flag_q, rsp_flag_d;
  logic [NREQ-1:0]   rsp_err_q, rsp_err_d;
`ifdef ALU_ARB_LOCK_EN
  logic              lock_active_q, lock_active_d;
  logic [PW-1:0]     lock_owner_q, lock_owner_d;
`endif

  logic [NREQ-1:0] eligible;
  logic            grant_valid;
  logic [PW-1:0]   grant_idx;
  logic            op_illegal;
  logic            op_keep_flag;

  // A full buffer is still eligible when it is being drained this same cycle.
  always_comb begin
    eligible = req_valid & (~rsp_valid_q | rsp_ready);
`ifdef ALU_ARB_LOCK_EN
    if (lock_active_q) eligible = eligible & (NREQ'(1) << lock_owner_q);
`endif
    if (!rst_n) eligible = '0;
  end

  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    idx         = 0;
    cand        = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    alu_srca  = '0;
    alu_srcb  = '0;
    alu_op    = 5'b00000;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
      alu_srca = req_srca[grant_idx*W +: W];
      alu_srcb = req_srcb[grant_idx*W +: W];
      alu_op   = req_op[grant_idx*5 +: 5];
    end
  end

  assign op_illegal   = (alu_op >= 5'b10010);
  assign op_keep_flag = (alu_op <= 5'b10000);

  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_ready;
    rsp_res_d   = rsp_res_q;
    rsp_flag_d  = rsp_flag_q;
    rsp_err_d   = rsp_err_q;
    rr_last_d   = rr_last_q;
`ifdef ALU_ARB_LOCK_EN
    lock_active_d = lock_active_q;
    lock_owner_d  = lock_owner_q;
`endif
    if (grant_valid) begin
      rsp_valid_d[grant_idx]         = 1'b1;
      rsp_res_d[grant_idx*W +: W]    = op_illegal ? '0 : alu_res;
      rsp_flag_d[grant_idx]          = op_keep_flag ? alu_flag : 1'b0;
      rsp_err_d[grant_idx]           = op_illegal;
      rr_last_d                      = grant_idx;
`ifdef ALU_ARB_LOCK_EN
      lock_active_d = req_lock[grant_idx];
      lock_owner_d  = grant_idx;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q   <= PW'(NREQ - 1);
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_flag_q  <= '0;
      rsp_err_q   <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_active_q <= 1'b0;
      lock_owner_q  <= '0;
`endif
    end else begin
      rr_last_q   <= rr_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flag_q  <= rsp_flag_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ALU_ARB_LOCK_EN
      lock_active_q <= lock_active_d;
      lock_owner_q  <= lock_owner_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flag  = rsp_flag_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a small ALU model
// Lock scenario is built only when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_srca;
  logic [NREQ*W-1:0] req_srcb;
  logic [NREQ*5-1:0] req_op;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [NREQ*W-1:0] rsp_res;
  logic [NREQ-1:0]   rsp_flag;
  logic [NREQ-1:0]   rsp_err;
  logic [W-1:0]      alu_srca;
  logic [W-1:0]      alu_srcb;
  logic [4:0]        alu_op;
  logic [W-1:0]      alu_res;
  logic              alu_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_srca  (req_srca),
    .req_srcb  (req_srcb),
    .req_op    (req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_flag  (rsp_flag),
    .rsp_err   (rsp_err),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_flag  (alu_flag)
  );

  // External ALU stand-in; unknown ops return non-zero data with flag set.
  always_comb begin
    alu_res  = alu_srca;
    alu_flag = 1'b0;
    case (alu_op)
      5'b00000: begin alu_res = alu_srca; alu_flag = 1'b0; end
      5'b00001: begin alu_res = alu_srca + alu_srcb; alu_flag = ((alu_srca + alu_srcb) == '0); end
      5'b00010: begin alu_res = alu_srcb - alu_srca; alu_flag = (alu_srcb < alu_srca); end
      5'b01011: begin alu_res = (alu_srca > alu_srcb) ? 32'd1 : 32'd0; alu_flag = (alu_srca > alu_srcb); end
      5'b10001: begin alu_res = alu_srcb << 16; alu_flag = 1'b1; end
      default:  begin alu_res = alu_srca ^ alu_srcb ^ 32'hdeadbeef; alu_flag = 1'b1; end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
    req_srca[i*W +: W] = a;
    req_srcb[i*W +: W] = b;
    req_op[i*5 +: 5]   = op;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_srca  = '0;
    req_srcb  = '0;
    req_op    = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = '0;
`endif
    set_req(0, 32'd3, 32'd5, 5'b00001);
    tick();
    n_checks++;
    if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    n_checks++;
    if (rsp_res !== '0 || rsp_flag !== 2'b00 || rsp_err !== 2'b00) begin
      n_fail++; $display("FAIL reset_rsp_data: got res=%h flag=%b err=%b expected all 0", rsp_res, rsp_flag, rsp_err);
    end
    n_checks++;
    if (alu_op !== 5'b00000 || alu_srca !== '0) begin
      n_fail++; $display("FAIL reset_alu_drive: got op=%b srca=%h expected 0", alu_op, alu_srca);
    end
    rst_n     = 1'b1;
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 32'd3, 32'd5, 5'b00001);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    n_checks++;
    if (alu_srca !== 32'd3 || alu_srcb !== 32'd5 || alu_op !== 5'b00001) begin
      n_fail++; $display("FAIL single_alu_drive: got %h %h %b expected 3 5 00001", alu_srca, alu_srcb, alu_op);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_res[31:0] !== 32'd8 || rsp_flag[0] !== 1'b0 || rsp_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got v=%b res=%0d flag=%b err=%b expected v=01 res=8 flag=0 err=0",
                         rsp_valid, rsp_res[31:0], rsp_flag[0], rsp_err[0]);
    end
    rsp_ready = 2'b11;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_drain: got %b expected 00", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    set_req(0, 32'd1, 32'd10, 5'b00010);
    set_req(1, 32'd7, 32'd2, 5'b01011);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      n_checks++;
      if (req_ready !== exp) begin n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp); end
      tick();
      n_checks++;
      if (exp == 2'b01) begin
        if (rsp_valid[0] !== 1'b1 || rsp_res[31:0] !== 32'd9) begin
          n_fail++; $display("FAIL rr_rsp0_%0d: got v=%b res=%0d expected v=1 res=9", i, rsp_valid[0], rsp_res[31:0]);
        end
      end else begin
        if (rsp_valid[1] !== 1'b1 || rsp_res[63:32] !== 32'd1 || rsp_flag[1] !== 1'b1) begin
          n_fail++; $display("FAIL rr_rsp1_%0d: got v=%b res=%0d flag=%b expected v=1 res=1 flag=1",
                             i, rsp_valid[1], rsp_res[63:32], rsp_flag[1]);
        end
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_skip_full();
    set_req(0, 32'd3, 32'd5, 5'b00001);
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick();
    set_req(0, 32'd100, 32'd23, 5'b00001);
    set_req(1, 32'd7, 32'd2, 5'b01011);
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req_ready !== 2'b10) begin n_fail++; $display("FAIL skip_grant%0d: got %b expected 10", i, req_ready); end
      tick();
      n_checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_res[31:0] !== 32'd8) begin
        n_fail++; $display("FAIL skip_hold%0d: got v=%b res=%0d expected v=1 res=8", i, rsp_valid[0], rsp_res[31:0]);
      end
    end
    rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL refill_grant: got %b expected 01", req_ready); end
    tick();
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_res[31:0] !== 32'd123) begin
      n_fail++; $display("FAIL refill_rsp: got v=%b res=%0d expected v=1 res=123", rsp_valid[0], rsp_res[31:0]);
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_opcodes();
    logic [4:0]  ops   [4] = '{5'b10101, 5'b10001, 5'b10000, 5'b10010};
    logic [31:0] a     [4] = '{32'd5, 32'd0, 32'd0, 32'd1};
    logic [31:0] b     [4] = '{32'd9, 32'h1234, 32'd0, 32'd2};
    logic [31:0] e_res [4] = '{32'd0, 32'h12340000, 32'hdeadbeef, 32'd0};
    logic        e_flg [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        e_err [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    req_valid = 2'b10;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      set_req(1, a[i], b[i], ops[i]);
      #1;
      n_checks++;
      if (req_ready !== 2'b10 || alu_op !== ops[i]) begin
        n_fail++; $display("FAIL op%0d_drive: got ready=%b op=%b expected ready=10 op=%b", i, req_ready, alu_op, ops[i]);
      end
      tick();
      n_checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_res[63:32] !== e_res[i] || rsp_flag[1] !== e_flg[i] || rsp_err[1] !== e_err[i]) begin
        n_fail++; $display("FAIL op%0d_rsp: got v=%b res=%h flag=%b err=%b expected v=1 res=%h flag=%b err=%b",
                           i, rsp_valid[1], rsp_res[63:32], rsp_flag[1], rsp_err[1], e_res[i], e_flg[i], e_err[i]);
      end
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 32'd3, 32'd5, 5'b00001);
    set_req(1, 32'd7, 32'd2, 5'b01011);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_grant0: got %b expected 01", req_ready); end
    tick();
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin n_fail++; $display("FAIL b2b_grant1: got %b expected 10", req_ready); end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL b2b_full: got %b expected 11", rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || rsp_res !== '0) begin
      n_fail++; $display("FAIL async_reset: got v=%b ready=%b res=%h expected all 0", rsp_valid, req_ready, rsp_res);
    end
    #1;
    rst_n     = 1'b1;
    rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_grant: got %b expected 01", req_ready); end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_res[31:0] !== 32'd8) begin
      n_fail++; $display("FAIL post_reset_rsp: got v=%b res=%0d expected v=01 res=8", rsp_valid, rsp_res[31:0]);
    end
    req_valid = 2'b00;
    tick();
  endtask

`ifdef ALU_ARB_LOCK_EN
  task automatic test_lock();
    logic [1:0] vld [6] = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    logic [1:0] lck [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] exp [6] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
    set_req(0, 32'd3, 32'd5, 5'b00001);
    set_req(1, 32'd7, 32'd2, 5'b01011);
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      req_valid = vld[i];
      req_lock  = lck[i];
      #1;
      n_checks++;
      if (req_ready !== exp[i]) begin n_fail++; $display("FAIL lock_c%0d: got %b expected %b", i, req_ready, exp[i]); end
      tick();
    end
    req_valid = 2'b00;
    req_lock  = 2'b00;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_skip_full();
    test_opcodes();
    test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. core execute stage, address-generation helper and debug port.
- Each requester has its own valid/ready request channel and its own valid/ready response channel with a one-entry response buffer.
- Arbitration is round-robin.
- The ALU is instantiated outside this block, which drives its operand/opcode inputs and samples its res/flag outputs.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accepted this cycle.
- req_srca  in  NREQ*W  flattened operand A; requester i at [i*W +: W].
- req_srcb  in  NREQ*W  flattened operand B.
- req_op  in  NREQ*5  flattened 5-bit alucontrol.
- rsp_valid  out  NREQ  response buffer i full.
- rsp_ready  in  NREQ  requester i consumes its response.
- rsp_res  out  NREQ*W  buffered result.
- rsp_flag  out  NREQ  buffered flag.
- rsp_err  out  NREQ  buffered illegal-opcode indicator.
- alu_srca  out  W  to ALU.
- alu_srcb  out  W  to ALU.
- alu_op  out  5  to ALU.
- alu_res  in  W  from ALU.
- alu_flag  in  1  from ALU.

Behaviour:
- Reset (asynchronous, rst_n low), all outputs 0:
  - req_ready, rsp_valid, rsp_res, rsp_flag, rsp_err all 0.
  - Round-robin pointer rr_last = NREQ-1, so requester 0 has first priority.
- Eligibility: requester i is eligible when req_valid[i]=1 and its buffer can accept, i.e. rsp_valid[i]=0, or rsp_valid[i]=1 with rsp_ready[i]=1 in the same cycle.
- Grant:
  - At most one grant per cycle, combinational.
  - Search starts at rr_last+1 modulo NREQ; the first eligible requester wins.
  - req_ready[g]=1 only for the winner g.
- ALU drive:
  - alu_srca/alu_srcb/alu_op carry the winner's operands.
  - When there is no winner they are driven to 0, opcode 00000 (pass-through); no x propagation.
- Capture:
  - On the clock edge of a grant, buffer g loads alu_res/alu_flag, rsp_valid[g] goes to 1, and rr_last goes to g.
  - Latency: request accepted in cycle N, response visible in cycle N+1.
  - Throughput: one operation per cycle across all requesters.
- Opcode legality:
  - Ops 00000..10000: res and flag stored as returned.
  - Op 10001 (load-upper shift): res stored, flag forced to 0.
  - Ops 10010..11111: rsp_err=1, res forced to 0, flag forced to 0.
  - rsp_err is 0 for every legal op.
- Response drain: rsp_valid[i] and rsp_ready[i] both 1 with no new grant to i: rsp_valid[i] clears next cycle.
- Simultaneous drain and refill of buffer i in one cycle: buffer loads the new result, rsp_valid stays 1.
- Data stability: response data is stable while rsp_valid=1 and rsp_ready=0. Requests must hold stable while req_valid=1 and req_ready=0.
- No eligible requesters: rr_last unchanged, no buffer change.
- A requester with a full, undrained buffer is skipped. This is not a deadlock for the others.
- Reset asserted mid-operation: every pending buffer is discarded immediately, with no partial responses.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock (NREQ bits).
  - A grant to i with req_lock[i]=1 sets lock owner i.
  - While locked, only i may be granted and others see req_ready=0, even if i is idle or ineligible.
  - A grant to i with req_lock[i]=0 releases the lock after that grant.
  - Reset clears the lock.
- When undefined: port absent, pure round-robin.

Test Plan:
- Reset then single request, req0 srca=3 srcb=5 op=00001 → req_ready[0]=1 in cycle 0; cycle 1 rsp_valid[0]=1 with rsp_res=8, rsp_flag=0, rsp_err=0.
- Both requesters valid every cycle, ops 00010 (srca=1 srcb=10) and 01011 (srca=7 srcb=2), rsp_ready held 1 → grants alternate 0,1,0,1; req0 results 9; req1 res=1, flag=1.
- req0 buffer full with rsp_ready[0]=0, both requesters valid → only req1 granted each cycle. Then raise rsp_ready[0] with req0 valid → same-cycle drain+refill, rsp_valid[0] stays 1 with new data.
- Illegal op 10101 on req1, and op 10001 with srcb=0x1234 → first gives rsp_err=1, res=0, flag=0; second gives res=0x12340000, flag=0, err=0.
- Back-to-back requests, rst_n pulsed low asynchronously mid-cycle → all rsp_valid drop immediately; after release requester 0 wins first.
- With ALU_ARB_LOCK_EN: req1 lock=1 for three ops while req0 valid → req0 stalled until req1 issues with lock=0, then req0 granted next cycle.
